alu_issue_ctrl: RTL and testbench

- Initiator side of the alu operand/opcode interface.
- Accepts R-type ALU requests (funct, rs, rt, shamt) over a valid/ready handshake and decodes funct into the 4-bit alu Op.
- Drives registered A/B/Op into the combinational alu, captures Result and flags one cycle later, and returns them over a valid/ready response channel.
- Sits between the decode stage and the alu in the multicycle datapath. Also keeps completed-op and overflow counters.

---
 rtl/alu_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational alu: accepts R-type requests, drives
// registered operands for one settle cycle, and returns the captured result.
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [31:0]      req_rs,
  input  logic [31:0]      req_rt,
  input  logic [4:0]       req_shamt,
  output logic [31:0]      alu_A,
  output logic [31:0]      alu_B,
  output logic [3:0]       alu_Op,
  input  logic [31:0]      alu_Result,
  input  logic             alu_Carryout,
  input  logic             alu_Overflow,
  input  logic             alu_Zero,
  input  logic             alu_Set,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  typedef struct packed {
    logic       legal;
    logic       shift;
    logic [3:0] op;
  } dec_t;

  state_t state, state_nxt;
  dec_t   dec;
  logic   accept, rsp_fire, slt_op, addsub_op;

  always_comb begin
    dec = '{legal: 1'b1, shift: 1'b0, op: OP_AND};
    case (req_funct)
      6'h24:   dec.op = OP_AND;
      6'h25:   dec.op = OP_OR;
      6'h26:   dec.op = OP_XOR;
      6'h20:   dec.op = OP_ADD;
      6'h22:   dec.op = OP_SUB;
      6'h2A:   dec.op = OP_SLT;
      6'h2B:   dec.op = OP_SLTU;
      6'h00:   begin dec.op = OP_SLL; dec.shift = 1'b1; end
      6'h02:   begin dec.op = OP_SRL; dec.shift = 1'b1; end
      default: dec.legal = 1'b0;
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  // alu_Op still names the op being answered: it only reloads on a legal accept.
  assign slt_op    = (alu_Op == OP_SLT) || (alu_Op == OP_SLTU);
  assign addsub_op = (alu_Op == OP_ADD) || (alu_Op == OP_SUB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = dec.legal ? EXEC : RESP;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_A  <= '0;
      alu_B  <= '0;
      alu_Op <= '0;
    end else if (accept && dec.legal) begin
      alu_A  <= dec.shift ? req_rt : req_rs;
      alu_B  <= dec.shift ? {27'b0, req_shamt} : req_rt;
      alu_Op <= dec.op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_illegal <= 1'b0;
    end else if (accept && !dec.legal) begin
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_illegal <= 1'b1;
    end else if (state == EXEC) begin
      rsp_result  <= slt_op ? {31'b0, alu_Set} : alu_Result;
      rsp_flags   <= {alu_Carryout, alu_Overflow, alu_Zero, alu_Set};
      rsp_illegal <= 1'b0;
    end
  end

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (rsp_fire && !rsp_illegal) begin
      if (op_count != '1) op_count <= op_count + 1'b1;
      if (addsub_op && rsp_flags[2] && (ovf_count != '1)) ovf_count <= ovf_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural alu, directed vector table, multi-cycle
// sequences and randomized ops checked against a spec-level reference.
module tb_alu_issue_ctrl;
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [3:0]  flags;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  shamt;
    exp_t        e;
  } vec_t;

  localparam longint SMAX = 64'sh7fffffff;
  localparam longint SMIN = -SMAX - 1;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, rsp_ready = 1'b0;
  logic [5:0]  req_funct = '0;
  logic [31:0] req_rs = '0, req_rt = '0;
  logic [4:0]  req_shamt = '0;

  logic        req_ready, rsp_valid, rsp_illegal;
  logic [31:0] alu_A, alu_B, alu_Result, rsp_result;
  logic [3:0]  alu_Op, rsp_flags;
  logic        alu_Carryout, alu_Overflow, alu_Zero, alu_Set;
  logic [15:0] op_count, ovf_count;

  logic        req_ready2, rsp_valid2, rsp_illegal2;
  logic [31:0] alu_A2, alu_B2, alu_Result2, rsp_result2;
  logic [3:0]  alu_Op2, rsp_flags2;
  logic        alu_Carryout2, alu_Overflow2, alu_Zero2, alu_Set2;
  logic [1:0]  op_count2, ovf_count2;

  int n_chk = 0, n_pass = 0;
  int ops = 0, ovfs = 0;
  logic [31:0] last_a = '0, last_b = '0;
  logic [3:0]  last_op = '0;

  always #5 clk = ~clk;

  // Behavioural alu: SLT/SLTU put the adder difference on Result so the
  // controller has to substitute Set itself.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic c, o, st;
    c = 1'b0; o = 1'b0; st = 1'b0; r = '0; s = '0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                  o = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd4: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                  o = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd5: begin r = a - b; st = $signed(a) < $signed(b); end
      4'd6: begin r = a - b; st = a < b; end
      4'd9: r = a << b[4:0];
      4'd10: r = a >> b[4:0];
      default: r = 32'hdeadbeef;
    endcase
    return {r, c, o, (r == 32'd0), st};
  endfunction

  always_comb {alu_Result, alu_Carryout, alu_Overflow, alu_Zero, alu_Set} = alu_model(alu_A, alu_B, alu_Op);
  always_comb {alu_Result2, alu_Carryout2, alu_Overflow2, alu_Zero2, alu_Set2} = alu_model(alu_A2, alu_B2, alu_Op2);

  alu_issue_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_rs(req_rs), .req_rt(req_rt), .req_shamt(req_shamt),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op), .alu_Result(alu_Result),
    .alu_Carryout(alu_Carryout), .alu_Overflow(alu_Overflow), .alu_Zero(alu_Zero), .alu_Set(alu_Set),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_illegal(rsp_illegal), .op_count(op_count), .ovf_count(ovf_count));

  alu_issue_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_funct(req_funct), .req_rs(req_rs), .req_rt(req_rt), .req_shamt(req_shamt),
    .alu_A(alu_A2), .alu_B(alu_B2), .alu_Op(alu_Op2), .alu_Result(alu_Result2),
    .alu_Carryout(alu_Carryout2), .alu_Overflow(alu_Overflow2), .alu_Zero(alu_Zero2), .alu_Set(alu_Set2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2), .rsp_flags(rsp_flags2),
    .rsp_illegal(rsp_illegal2), .op_count(op_count2), .ovf_count(ovf_count2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_counts(input string tag);
    chk({tag, "_op_count"},  32'(op_count),   32'(sat(ops, 65535)));
    chk({tag, "_ovf_count"}, 32'(ovf_count),  32'(sat(ovfs, 65535)));
    chk({tag, "_op_count2"}, 32'(op_count2),  32'(sat(ops, 3)));
    chk({tag, "_ovf_count2"},32'(ovf_count2), 32'(sat(ovfs, 3)));
  endtask

  // Spec-level reference: what the block must return for one request.
  function automatic exp_t ref_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] sh);
    exp_t e;
    logic [63:0] u;
    longint sr;
    logic c, o, s, z, zfix;
    e = '0; e.a = rs; e.b = rt;
    c = 1'b0; o = 1'b0; s = 1'b0; z = 1'b0; zfix = 1'b0;
    case (f)
      6'h24: begin e.op = 4'd0; e.res = rs & rt; end
      6'h25: begin e.op = 4'd1; e.res = rs | rt; end
      6'h26: begin e.op = 4'd2; e.res = rs ^ rt; end
      6'h20: begin e.op = 4'd3; u = 64'(rs) + 64'(rt); e.res = u[31:0]; c = u[32];
                   sr = longint'($signed(rs)) + longint'($signed(rt)); o = (sr > SMAX) || (sr < SMIN); end
      6'h22: begin e.op = 4'd4; e.res = rs - rt; c = (rs >= rt);
                   sr = longint'($signed(rs)) - longint'($signed(rt)); o = (sr > SMAX) || (sr < SMIN); end
      6'h2A: begin e.op = 4'd5; s = $signed(rs) < $signed(rt); e.res = {31'b0, s}; z = (rs == rt); zfix = 1'b1; end
      6'h2B: begin e.op = 4'd6; s = rs < rt; e.res = {31'b0, s}; z = (rs == rt); zfix = 1'b1; end
      6'h00: begin e.op = 4'd9;  e.res = rt << sh; e.a = rt; e.b = {27'b0, sh}; end
      6'h02: begin e.op = 4'd10; e.res = rt >> sh; e.a = rt; e.b = {27'b0, sh}; end
      default: begin e.ill = 1'b1; zfix = 1'b1; end
    endcase
    if (!zfix) z = (e.res == 32'd0);
    e.flags = e.ill ? 4'b0 : {c, o, z, s};
    return e;
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic issue(input string nm, input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sh, input exp_t e, input int hold);
    int t;
    logic [31:0] ea, eb;
    logic [3:0] eop;
    req_funct = f; req_rs = rs; req_rt = rt; req_shamt = sh; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) begin n_chk++; $display("FAIL %s accept_timeout: req_ready stuck 0, want 1", nm); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (e.ill) begin ea = last_a; eb = last_b; eop = last_op; end
    else begin ea = e.a; eb = e.b; eop = e.op; last_a = e.a; last_b = e.b; last_op = e.op; end
    chk({nm, "_alu_A"},  alu_A, ea);
    chk({nm, "_alu_B"},  alu_B, eb);
    chk({nm, "_alu_Op"}, 32'(alu_Op), 32'(eop));
    chk({nm, "_busy"},   32'(req_ready), 32'd0);
    t = 1;
    while (!rsp_valid && t < 10) begin @(posedge clk); #1; t++; end
    chk({nm, "_latency"}, 32'(t), e.ill ? 32'd1 : 32'd2);
    chk({nm, "_result"},  rsp_result, e.res);
    chk({nm, "_flags"},   32'(rsp_flags), 32'(e.flags));
    chk({nm, "_illegal"}, 32'(rsp_illegal), 32'(e.ill));
    for (int i = 0; i < hold; i++) begin
      req_valid = ~req_valid; req_funct = 6'h20;
      @(posedge clk); #1;
      chk({nm, "_hold_valid"},  32'(rsp_valid), 32'd1);
      chk({nm, "_hold_ready"},  32'(req_ready), 32'd0);
      chk({nm, "_hold_result"}, rsp_result, e.res);
      chk({nm, "_hold_flags"},  32'(rsp_flags), 32'(e.flags));
      chk({nm, "_hold_opcnt"},  32'(op_count), 32'(sat(ops, 65535)));
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (!e.ill) begin
      ops++;
      if ((f == 6'h20 || f == 6'h22) && e.flags[2]) ovfs++;
    end
    chk({nm, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_idle"},     32'(req_ready), 32'd1);
    chk({nm, "_hold_A"},   alu_A, last_a);
    chk({nm, "_hold_Op"},  32'(alu_Op), 32'(last_op));
    chk_counts(nm);
  endtask

  // Back-to-back stream with rsp_ready held high; checks the issue interval.
  task automatic stream(input string nm, input logic [5:0] f, input int exp_gap, input logic legal);
    int prev, hs, t;
    req_funct = f; req_rs = 32'd1; req_rt = 32'd1; req_shamt = '0;
    req_valid = 1'b1; rsp_ready = 1'b1; prev = -1; hs = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_valid && req_ready) begin
        if (prev >= 0) chk({nm, "_interval"}, 32'(c - prev), 32'(exp_gap));
        prev = c;
      end
      if (rsp_valid && rsp_ready) hs++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; t = 0;
    while (!req_ready && t < 10) begin
      if (rsp_valid && rsp_ready) hs++;
      @(posedge clk); #1; t++;
    end
    rsp_ready = 1'b0;
    chk({nm, "_drained"}, 32'(req_ready), 32'd1);
    if (legal) begin ops += hs; last_a = 32'd1; last_b = 32'd1; last_op = 4'd3; end
    chk_counts(nm);
  endtask

  vec_t vecs[12];
  logic [5:0] legal_f[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] spec[6];
    logic [5:0] f;
    logic [31:0] rs, rt;
    logic [4:0] sh;
    vecs[0]  = '{6'h20, 32'h0000003f, 32'h7fffffff, 5'd0, '{32'h8000003e, 32'h0000003f, 32'h7fffffff, 4'd3, 4'b0100, 1'b0}};
    vecs[1]  = '{6'h00, 32'hffffffff, 32'haaaaaaaa, 5'd6, '{32'haaaaaa80, 32'haaaaaaaa, 32'h00000006, 4'd9, 4'b0000, 1'b0}};
    vecs[2]  = '{6'h2A, 32'h1aaaaaa1, 32'h1aaaaaaa, 5'd0, '{32'h00000001, 32'h1aaaaaa1, 32'h1aaaaaaa, 4'd5, 4'b0001, 1'b0}};
    vecs[3]  = '{6'h2B, 32'h80000001, 32'h80000001, 5'd0, '{32'h00000000, 32'h80000001, 32'h80000001, 4'd6, 4'b0010, 1'b0}};
    vecs[4]  = '{6'h18, 32'h12345678, 32'h9abcdef0, 5'd3, '{32'h00000000, 32'h0, 32'h0, 4'd0, 4'b0000, 1'b1}};
    vecs[5]  = '{6'h24, 32'h0000f0f0, 32'h0000ff00, 5'd0, '{32'h0000f000, 32'h0000f0f0, 32'h0000ff00, 4'd0, 4'b0000, 1'b0}};
    vecs[6]  = '{6'h25, 32'h0000000f, 32'h000000f0, 5'd0, '{32'h000000ff, 32'h0000000f, 32'h000000f0, 4'd1, 4'b0000, 1'b0}};
    vecs[7]  = '{6'h26, 32'h000000ff, 32'h000000ff, 5'd0, '{32'h00000000, 32'h000000ff, 32'h000000ff, 4'd2, 4'b0010, 1'b0}};
    vecs[8]  = '{6'h22, 32'h00000005, 32'h00000003, 5'd0, '{32'h00000002, 32'h00000005, 32'h00000003, 4'd4, 4'b1000, 1'b0}};
    vecs[9]  = '{6'h22, 32'h80000000, 32'h00000001, 5'd0, '{32'h7fffffff, 32'h80000000, 32'h00000001, 4'd4, 4'b1100, 1'b0}};
    vecs[10] = '{6'h02, 32'h00000000, 32'h80000000, 5'd4, '{32'h08000000, 32'h80000000, 32'h00000004, 4'd10, 4'b0000, 1'b0}};
    vecs[11] = '{6'h20, 32'hffffffff, 32'h00000001, 5'd0, '{32'h00000000, 32'hffffffff, 32'h00000001, 4'd3, 4'b1010, 1'b0}};
    legal_f = '{6'h24, 6'h25, 6'h26, 6'h20, 6'h22, 6'h2A, 6'h2B, 6'h00, 6'h02};
    spec = '{32'h0, 32'h7fffffff, 32'h80000000, 32'hffffffff, 32'h1, 32'h80000001};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_A", alu_A, 32'd0);
    chk("rst_alu_B", alu_B, 32'd0);
    chk("rst_alu_Op", 32'(alu_Op), 32'd0);
    chk("rst_rsp", {rsp_result[27:0], rsp_flags}, 32'd0);
    chk("rst_illegal", 32'(rsp_illegal), 32'd0);
    chk("rst_dut2", {rsp_result2[21:0], rsp_flags2, rsp_illegal2, rsp_valid2, alu_Op2}, 32'd0);
    chk("rst_dut2_ab", alu_A2 | alu_B2, 32'd0);
    chk("rst_dut2_ready", 32'(req_ready2), 32'd1);
    chk_counts("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset while the SUB is in EXEC: response discarded, nothing counted.
    req_funct = 6'h22; req_rs = 32'h8fffffff; req_rt = 32'h80000000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("exec_loaded_A", alu_A, 32'h8fffffff);
    chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_alu", alu_A | alu_B | 32'(alu_Op), 32'd0);
    chk("mid_rst_rsp", rsp_result | 32'(rsp_flags) | 32'(rsp_illegal) | 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk_counts("post_rst");

    // Directed vectors; first one doubles as the 5-cycle backpressure case.
    for (int i = 0; i < 12; i++)
      issue($sformatf("vec%0d", i), vecs[i].funct, vecs[i].rs, vecs[i].rt, vecs[i].shamt, vecs[i].e,
            (i == 0) ? 5 : i % 2);

    stream("stream_legal", 6'h20, 3, 1'b1);
    stream("stream_illegal", 6'h3f, 2, 1'b0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 9) f = 6'($urandom_range(0, 63));
      else f = legal_f[$urandom_range(0, 8)];
      rs = ($urandom_range(0, 1) == 1) ? spec[$urandom_range(0, 5)] : $urandom;
      rt = ($urandom_range(0, 1) == 1) ? spec[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rt = rs;
      sh = 5'($urandom_range(0, 31));
      issue($sformatf("rnd%0d", n), f, rs, rt, sh, ref_op(f, rs, rt, sh), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
